// File: rtl/toggle_led_sequencer.sv
// -----------------------------------------------------------------------------
// toggle_led_sequencer
//
// Advances a one-hot LED pattern by one position on every change (either
// polarity) of the upstream toggle signal. In wrap mode the lit LED chases
// 0..N-1 and starts again at 0; in bounce mode it ping-pongs 0..N-1..0. Each
// completed sweep (a wrap, or a full round trip in bounce mode) produces a
// one-cycle pulse and bumps a saturating sweep counter.
//
// Parameters:
//   NUM_OUTPUTS   number of one-hot outputs (2..16)
//   COUNT_WIDTH   width of the saturating sweep counter
//
// Ports:
//   i_Clk          system clock, rising edge
//   i_Reset        synchronous active-high reset
//   i_Enable       run when high; idle with all LEDs off when low
//   i_Toggle       toggle output of the upstream stage
//   i_Bounce       0 = wrap (chaser), 1 = bounce (ping-pong)
//   o_Sel          one-hot LED select, all zeros when idle
//   o_Index        binary index of the lit LED
//   o_Sweep_Done   one-cycle pulse per completed sweep
//   o_Sweep_Count  number of completed sweeps, saturating
// -----------------------------------------------------------------------------
module toggle_led_sequencer #(
  parameter int NUM_OUTPUTS = 4,
  parameter int COUNT_WIDTH = 8,
  localparam int IDX_W = $clog2(NUM_OUTPUTS)
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Enable,
  input  logic                   i_Toggle,
  input  logic                   i_Bounce,
  output logic [NUM_OUTPUTS-1:0] o_Sel,
  output logic [IDX_W-1:0]       o_Index,
  output logic                   o_Sweep_Done,
  output logic [COUNT_WIDTH-1:0] o_Sweep_Count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_UP   = 2'd1,
    RUN_DOWN = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0]       LAST      = IDX_W'(NUM_OUTPUTS - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [NUM_OUTPUTS-1:0] SEL_ONE   = NUM_OUTPUTS'(1);

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [NUM_OUTPUTS-1:0]   sel_q, sel_d;
  logic                     done_q, done_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic                     toggle_prev;
  logic                     edge_seen;
  logic                     sweep;

  // Either polarity of the toggle counts as one step.
  assign edge_seen = (i_Toggle != toggle_prev);

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    count_d = count_q;
    sweep   = 1'b0;

    if (!i_Enable) begin
      // Disable wins over a coincident toggle edge.
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Entry cycle only lights LED 0; a coincident edge is not consumed.
          state_d = RUN_UP;
          idx_d   = '0;
        end
        RUN_UP, RUN_DOWN: begin
          if (edge_seen) begin
            if (state_q == RUN_DOWN && i_Bounce && idx_q != '0) begin
              idx_d   = idx_q - IDX_W'(1);
              state_d = RUN_DOWN;
              if (idx_q == IDX_W'(1)) begin
                // Back at LED 0: the round trip is complete.
                sweep   = 1'b1;
                state_d = RUN_UP;
              end
            end else begin
              // Upward rule, also used when bounce is dropped while descending.
              state_d = RUN_UP;
              if (idx_q != LAST) begin
                idx_d = idx_q + IDX_W'(1);
              end else if (i_Bounce) begin
                idx_d = LAST - IDX_W'(1);
                // With only two LEDs the turn-around already lands on 0.
                if (LAST == IDX_W'(1)) sweep = 1'b1;
                else                   state_d = RUN_DOWN;
              end else begin
                idx_d = '0;
                sweep = 1'b1;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end

    if (sweep) begin
      done_d = 1'b1;
      if (count_q != COUNT_MAX) count_d = count_q + COUNT_WIDTH'(1);
    end

    sel_d = (state_d == IDLE) ? '0 : (SEL_ONE << idx_d);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk) begin
    // Tracked in every state and through reset, so re-enable never sees a
    // stale edge.
    toggle_prev <= i_Toggle;
    if (i_Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sel_q   <= '0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign o_Sel         = sel_q;
  assign o_Index       = idx_q;
  assign o_Sweep_Done  = done_q;
  assign o_Sweep_Count = count_q;

endmodule

// File: doc/toggle_led_sequencer.md
Name: toggle_led_sequencer

Overview:
- Downstream consumer of the count-and-toggle stage in the demux/LFSR LED project.
- Each change of the toggle input (either edge) advances a one-hot LED pattern across NUM_OUTPUTS outputs.
- Supports a wrap (chaser) mode and a bounce (ping-pong) mode, and counts completed sweeps.
- Sits between the toggle generator and the board LED pins.

Parameters:
- NUM_OUTPUTS, 4, number of one-hot outputs; legal range 2 to 16.
- COUNT_WIDTH, 8, width of the sweep counter.

Ports:
- i_Clk  input  1  system clock; all logic on rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Enable  input  1  run when high; idle with all outputs off when low. Same enable that drives the toggle stage.
- i_Toggle  input  1  toggle output of the upstream stage.
- i_Bounce  input  1  0 = wrap mode, 1 = bounce mode.
- o_Sel  output  NUM_OUTPUTS  one-hot LED select; all zeros when idle.
- o_Index  output  $clog2(NUM_OUTPUTS)  binary index of the lit output.
- o_Sweep_Done  output  1  single-cycle pulse when a sweep completes.
- o_Sweep_Count  output  COUNT_WIDTH  number of completed sweeps; saturating.

Behaviour:
- One clock, i_Clk. Reset is synchronous and active-high on i_Reset. All outputs are registered.
- Reset, when i_Reset is high at a clock edge:
  - state IDLE; o_Sel = 0; o_Index = 0; o_Sweep_Done = 0; o_Sweep_Count = 0.
  - r_Toggle_Prev loads i_Toggle.
  - Reset has priority over every other event.
- Edge detect: edge = (i_Toggle != r_Toggle_Prev). r_Toggle_Prev <= i_Toggle every cycle, in every state.
- States: IDLE, RUN_UP, RUN_DOWN.
- IDLE:
  - o_Sel = 0, o_Index = 0, o_Sweep_Done = 0.
  - i_Enable high at a clock edge: go to RUN_UP, o_Index = 0, o_Sel = 1 on the next cycle. No advance on that entry cycle, even if an edge is present.
- RUN_UP (clock edge with i_Enable = 1 and edge = 1):
  - o_Index < NUM_OUTPUTS-1: o_Index +1.
  - o_Index = NUM_OUTPUTS-1 with i_Bounce = 0: o_Index -> 0, o_Sweep_Done pulses, count increments.
  - o_Index = NUM_OUTPUTS-1 with i_Bounce = 1: o_Index -> NUM_OUTPUTS-2, go to RUN_DOWN.
- RUN_DOWN (edge, enabled):
  - i_Bounce = 0 on this edge: go to RUN_UP and apply the RUN_UP rule to the current index, i.e. o_Index +1, wrapping to 0 with a sweep if at NUM_OUTPUTS-1.
  - i_Bounce = 1 and o_Index > 0: o_Index -1. Reaching index 0 completes the round trip: o_Sweep_Done pulses, count increments, go to RUN_UP on that same transition.
- i_Bounce is sampled only on edge cycles; mid-run changes take effect at the next edge.
- No edge: state and index hold; o_Sweep_Done = 0.
- Always o_Sel = (1 << o_Index) while not IDLE, updated in the same register stage as o_Index.
- Latency: i_Toggle change sampled at edge n; o_Sel/o_Index/o_Sweep_Done update at edge n+1.
- o_Sweep_Done is high for exactly one cycle per completed sweep.
- o_Sweep_Count holds at 2^COUNT_WIDTH-1. o_Sweep_Done still pulses when the count is saturated.
- i_Enable low at a clock edge in any RUN state:
  - next state IDLE; o_Sel = 0, o_Index = 0, o_Sweep_Done = 0.
  - o_Sweep_Count is retained; only reset clears it.
  - An edge coinciding with the disable is ignored.
- The upstream stage forces i_Toggle = 0 while disabled. Since r_Toggle_Prev tracks continuously, re-enable produces no spurious edge.
- i_Enable and i_Reset both high: reset wins.

Test Plan:
- Reset, then i_Enable = 1, i_Bounce = 0, NUM_OUTPUTS = 4, 8 toggle edges spaced 10 clk -> o_Index 0,1,2,3,0,1,2,3,0. o_Sweep_Done pulses twice, 1 clk each, 1 clk after the 4th and 8th edges. o_Sweep_Count = 2.
- i_Bounce = 1, 6 edges -> o_Index 0,1,2,3,2,1,0. One sweep pulse after the 6th edge. o_Sel = 0001,0010,0100,1000,0100,0010,0001.
- In RUN_DOWN at index 2 (bounce), set i_Bounce = 0, 2 edges -> index 3 then 0, with a sweep pulse on the wrap.
- Drop i_Enable at index 2 on the same cycle as a toggle edge -> next cycle o_Sel = 0, o_Index = 0, no pulse, count unchanged. Re-enable with i_Toggle = 0 -> o_Sel = 0001, no advance until a real edge.
- COUNT_WIDTH = 2, 5 wrap sweeps -> count 1,2,3,3,3; five sweep pulses.
- Assert i_Reset mid-run at index 3 with a simultaneous edge -> next cycle all outputs 0, state IDLE, count 0; i_Reset and i_Enable both high -> stays IDLE.
